// File: rtl/sa_result_collector.sv
// sa_result_collector: collects result rows shifted out of a 4-lane
// systolic array, saturates each lane to OUT_W bits, tags the row with
// its index inside the frame and queues it in a small FIFO for a
// valid/ready consumer. Sticky flags report clamping and dropped rows.
module sa_result_collector #(
  parameter int ACC_W = 20,
  parameter int OUT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    out_sign,
  input  logic signed [ACC_W-1:0] pe_out_0,
  input  logic signed [ACC_W-1:0] pe_out_1,
  input  logic signed [ACC_W-1:0] pe_out_2,
  input  logic signed [ACC_W-1:0] pe_out_3,
  input  logic                    clear,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [4*OUT_W-1:0]      res_data,
  output logic [1:0]              res_row,
  output logic                    res_last,
  output logic                    frame_done,
  output logic                    sat_seen,
  output logic                    err_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = 4 * OUT_W + 2;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [OUT_W-1:0] sat_lane(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    else                  return v[OUT_W-1:0];
  endfunction

  function automatic logic is_clamped(input logic signed [ACC_W-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t                    state, state_nxt;
  logic [1:0]                row_cnt, row_cnt_nxt, row_tag;

  logic signed [ACC_W-1:0]   lane_in [4];
  logic signed [OUT_W-1:0]   lane_p0 [4];
  logic [3:0]                clamp_p0;
  logic                      vld_p0;
  logic [ENT_W-1:0]          entry_p0;

  logic [ENT_W-1:0]          mem_p1 [DEPTH];
  logic [ENT_W-1:0]          head_p1;
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          occupancy;
  logic                      full, push, pop, drop;

  // ---- stage p0: combinational saturation and row tagging ----
  assign lane_in[0] = pe_out_0;
  assign lane_in[1] = pe_out_1;
  assign lane_in[2] = pe_out_2;
  assign lane_in[3] = pe_out_3;
  assign vld_p0     = out_sign;

  // Clamp every lane and flag which lanes were clamped.
  always_comb begin
    clamp_p0 = '0;
    for (int i = 0; i < 4; i++) begin
      lane_p0[i]  = sat_lane(lane_in[i]);
      clamp_p0[i] = is_clamped(lane_in[i]);
    end
  end

  assign entry_p0 = {lane_p0[3], lane_p0[2], lane_p0[1], lane_p0[0], row_tag};

  // ---- stage p1: row FIFO ----
  assign res_valid = (occupancy != '0);
  assign full      = (occupancy == CNT_W'(DEPTH));
  assign pop       = res_valid & res_ready;
  assign push      = vld_p0 & (~full | pop);
  assign drop      = vld_p0 & full & ~pop;

  assign head_p1   = mem_p1[rd_ptr];
  // Outputs read zero while empty so reset clears them without resetting storage.
  assign res_data  = res_valid ? head_p1[ENT_W-1:2] : '0;
  assign res_row   = res_valid ? head_p1[1:0] : 2'd0;
  assign res_last  = res_valid & (head_p1[1:0] == 2'd3);

  // Row storage: written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (push) mem_p1[wr_ptr] <= entry_p0;
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Frame FSM state and row counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      row_cnt <= 2'd0;
    end else begin
      state   <= state_nxt;
      row_cnt <= row_cnt_nxt;
    end
  end

  // Next state, row tag for the incoming row, and row counter update.
  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    row_tag     = 2'd0;
    case (state)
      IDLE: begin
        if (out_sign) begin
          row_tag     = 2'd0;
          row_cnt_nxt = 2'd1;
          state_nxt   = COLLECT;
        end
      end
      COLLECT: begin
        if (out_sign) begin
          row_tag     = row_cnt;
          row_cnt_nxt = row_cnt + 2'd1;
          if (row_cnt == 2'd3) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (out_sign) begin
          row_tag     = 2'd0;
          row_cnt_nxt = 2'd1;
          state_nxt   = COLLECT;
        end else if ((occupancy == '0) && !push) begin
          state_nxt   = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        row_cnt_nxt = 2'd0;
      end
    endcase
  end

  // Frame completion pulse and sticky status; a set on the same edge beats clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_done   <= 1'b0;
      sat_seen     <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      frame_done <= pop & res_last;
      if (push && (clamp_p0 != 4'd0)) sat_seen <= 1'b1;
      else if (clear)                 sat_seen <= 1'b0;
      if (drop)       err_overflow <= 1'b1;
      else if (clear) err_overflow <= 1'b0;
    end
  end

endmodule

// File: doc/sa_result_collector.md
SA_RESULT_COLLECTOR -- requirements
Module: sa_result_collector

Interface
REQ-001 SHALL have parameter: ACC_W, 20, width of each signed PE accumulator lane.
REQ-002 SHALL have parameter: OUT_W, 16, width of each signed saturated result lane; OUT_W <= ACC_W.
REQ-003 SHALL have parameter: DEPTH, 4, row FIFO entries; power of two, >= 2.
REQ-004 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port: rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: out_sign  input  1  array shift-out enable; one result row is present on pe_out_* in each cycle it is high.
REQ-007 SHALL have port: pe_out_0..pe_out_3  input  ACC_W each  signed lane results of the current row.
REQ-008 SHALL have port: clear  input  1  synchronous clear of sticky flags.
REQ-009 SHALL have port: res_valid  output  1  FIFO head row valid.
REQ-010 SHALL have port: res_ready  input  1  downstream accepts head row.
REQ-011 SHALL have port: res_data  output  4*OUT_W  head row, lane 0 in LSBs.
REQ-012 SHALL have port: res_row  output  2  row index (0..3) of head row within its frame.
REQ-013 SHALL have port: res_last  output  1  head row is row 3.
REQ-014 SHALL have port: frame_done  output  1  one-cycle pulse when a row-3 entry is accepted.
REQ-015 SHALL have port: sat_seen  output  1  sticky; any lane clamped since last clear.
REQ-016 SHALL have port: err_overflow  output  1  sticky; a row was dropped because the FIFO was full.

Function
REQ-017 SHALL saturate each lane combinationally before the FIFO write: a value above 2^(OUT_W-1)-1 SHALL clamp to that maximum, a value below -2^(OUT_W-1) SHALL clamp to that minimum, and any other value SHALL be passed through as its low OUT_W bits.
REQ-018 SHALL push {saturated lanes, row_cnt} into the FIFO on each rising edge with out_sign=1 that is not a drop.
REQ-019 SHALL present a pushed row on res_valid/res_data one cycle after the capture edge at the earliest (registered FIFO, no bypass).
REQ-020 SHALL pop the head on any edge with res_valid=1 and res_ready=1.
REQ-021 SHALL hold res_data, res_row and res_last stable while res_valid=1 and res_ready=0.
REQ-022 SHALL accept a push on a full FIFO if a pop occurs on the same edge.
REQ-023 SHALL drop the row when the FIFO is full and no pop occurs on the same edge. A drop SHALL set err_overflow, SHALL still advance row_cnt, and SHALL leave the FIFO unchanged.
REQ-024 SHALL leave the occupancy unchanged on a simultaneous push and pop. Occupancy SHALL range from 0 to DEPTH, and the pointers SHALL wrap modulo DEPTH.
REQ-025 SHALL implement FSM IDLE, COLLECT, DRAIN:
  - IDLE -> COLLECT on out_sign=1; that row is row 0.
  - COLLECT: row_cnt increments on each out_sign=1, wrapping 3 -> 0. After the row-3 capture, the FSM SHALL go to DRAIN.
  - DRAIN -> IDLE when the FIFO is empty and no push occurs this edge.
  - DRAIN with out_sign=1 -> COLLECT; that row is row 0 of the next frame.
REQ-026 SHALL reset row_cnt to 0 on every entry to COLLECT from IDLE or DRAIN.
REQ-027 SHALL assert frame_done for exactly one cycle, the cycle after the edge at which a res_last=1 row is popped.
REQ-028 SHALL set sat_seen on any push with a clamped lane.
REQ-029 SHALL clear sat_seen and err_overflow when clear=1, unless a set event occurs on the same edge; a set SHALL win over clear.
REQ-030 SHALL drive res_valid combinationally from (occupancy != 0) only.

Reset
REQ-031 SHALL, with rstn=0, immediately force:
  - state = IDLE, row_cnt = 0, occupancy = 0 and both FIFO pointers = 0;
  - res_valid, frame_done, sat_seen and err_overflow = 0;
  - res_data and res_row = 0 and res_last = 0.
REQ-032 SHALL discard all FIFO contents when reset is asserted mid-frame, and SHALL NOT assert frame_done for the aborted frame.

Verification
REQ-033 SHALL pass this scenario: out_sign high 4 cycles with rows of small values, res_ready=1 -> four rows appear with res_row 0,1,2,3 one cycle after each capture; res_last only on row 3; one frame_done pulse; FSM ends in IDLE.
REQ-034 SHALL pass this scenario: lane value 0x7FFFF (ACC_W=20) and lane value -40000 -> output lanes 0x7FFF and 0x8000; sat_seen=1 until clear.
REQ-035 SHALL pass this scenario: res_ready=0 with 5 rows pushed (DEPTH=4) -> the fifth row is dropped and err_overflow=1; then res_ready=1 -> rows 0..3 drain in order.
REQ-036 SHALL pass this scenario: full FIFO with res_ready=1 and out_sign=1 on the same edge -> push and pop both occur, no drop, occupancy stays 4.
REQ-037 SHALL pass this scenario: second frame starts (out_sign=1) while in DRAIN with 2 rows queued -> the new row is tagged res_row=0, order is preserved, and there are two frame_done pulses in total.
REQ-038 SHALL pass this scenario: rstn pulsed low after 2 rows are captured -> all outputs 0 at once; next out_sign after release is tagged row 0.
